ioctl_mem_scheduler: RTL and testbench
======================================

Name: ioctl_mem_scheduler

Overview:
- Sits between the data_io download port and the core's single 16-bit memory port (SDRAM controller front end).
- Packs the ioctl byte stream into 16-bit word writes with byte enables and buffers them in a small word FIFO.
- Paces data_io through clkref_n and arbitrates the memory port between download writes and core (CPU) accesses.

Parameters:
- FIFO_DEPTH, 4, word FIFO entries (power of 2, >=2).
- CLKREF_DIV, 4, minimum clk_sys cycles between clkref_n strobes (>=2).
- DL_BURST, 2, maximum consecutive download words granted while cpu_req is pending (>=1).

Ports:
- clk_sys  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- ioctl_download  in  1  download active.
- ioctl_wr  in  1  byte strobe.
- ioctl_addr  in  25  byte address.
- ioctl_dout  in  8  byte data.
- clkref_n  out  1  active-low one-cycle strobe permitting one ioctl byte.
- dl_busy  out  1  download active, or FIFO/staging not yet drained.
- cpu_req  in  1  level request.
- cpu_we  in  1  write.
- cpu_addr  in  24  word address.
- cpu_wdata  in  16  write data.
- cpu_be  in  2  byte enables.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_rdata  out  16  read data, valid with cpu_ack.
- mem_req  out  1  memory request.
- mem_we  out  1  memory write.
- mem_addr  out  24  word address.
- mem_wdata  out  16  write data.
- mem_be  out  2  byte enables.
- mem_ack  in  1  one-cycle completion pulse.
- mem_rdata  in  16  memory read data, valid with mem_ack.

Behaviour:
- Reset values: clkref_n=1, dl_busy=0, cpu_ack=0, cpu_rdata=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_be=0. FIFO and staging register are empty.
- Packing:
  - A byte at ioctl_addr with bit 0 = 0 goes to data[7:0], be=01; bit 0 = 1 goes to data[15:8], be=10. Word address = ioctl_addr[24:1].
  - Staging register holds {addr, data, be, valid}.
  - An incoming byte whose word address equals staging.addr and whose lane is not already enabled merges into staging (be ORed).
  - Any other incoming byte pushes staging to the FIFO and loads the new byte into staging.
  - Staging is pushed immediately once be==11.
  - A falling edge of ioctl_download pushes any valid partial staging word.
- Pacing:
  - clkref_n goes low for exactly 1 cycle when all of these hold: ioctl_download=1, FIFO free entries >= 2, and at least CLKREF_DIV cycles since the previous strobe.
  - Otherwise clkref_n stays high. This guarantees space for the byte data_io may write on the cycle after the strobe.
- Arbiter FSM states: IDLE, DL, CPU.
  - IDLE: if the FIFO is non-empty and (cpu_req=0 or the burst counter < DL_BURST), pop the FIFO head, drive mem_* with we=1, mem_req=1, go to DL. Else if cpu_req=1 and cpu_ack=0, latch the cpu_* signals onto mem_*, mem_req=1, go to CPU.
  - DL: hold mem_* stable until mem_ack. On mem_ack: mem_req=0 next cycle, burst counter +1, return to IDLE.
  - CPU: hold mem_* until mem_ack. On mem_ack: cpu_ack=1 next cycle with cpu_rdata=mem_rdata (read) or unchanged (write), burst counter cleared, mem_req=0, return to IDLE.
  - The burst counter also clears whenever cpu_req=0 in IDLE.
  - cpu_req is ignored on the cycle cpu_ack is high, so the requester has one cycle to drop it.
- Simultaneous events:
  - FIFO push and pop in the same cycle are both honoured.
  - A staging push and a falling-edge flush in the same cycle push the older word first, the flush word next cycle.
  - The FIFO never overflows; overflow is an assertion failure in the bench.
- dl_busy = ioctl_download | staging.valid | FIFO non-empty | state==DL.
- Reset mid-operation: all state clears at once and mem_req drops asynchronously. In-flight memory transactions are abandoned; the memory controller must tolerate this.
- Latency: a merged word reaches mem_req no earlier than 2 cycles after its second ioctl_wr when the arbiter is idle.

Test Plan:
- Download 4 bytes 0x11,0x22,0x33,0x44 at addr 0..3 -> mem writes addr 0 data 0x2211 be 11, then addr 1 data 0x4433 be 11, no CPU ack generated.
- Odd start: single byte 0xAB at addr 5, then ioctl_download falls -> one write addr 2, data[15:8]=0xAB, be 10.
- CPU read with mem_ack delayed 7 cycles, mem_rdata=0xBEEF -> mem_req held 7 cycles with stable addr; cpu_ack one cycle later with cpu_rdata=0xBEEF.
- Contention: FIFO holding 3 words, cpu_req held, DL_BURST=2 -> order DL, DL, CPU, DL; cpu_ack after the third grant.
- Backpressure: mem_ack withheld 100 cycles during download -> clkref_n strobes stop once free entries < 2, no FIFO overflow; strobes resume after acks, spaced >= CLKREF_DIV cycles.
- Assert reset_n low while in DL with mem_req high -> mem_req, clkref_n=1, dl_busy=0 immediately; after release the FIFO is empty and the FSM is in IDLE.

Source files
------------

// File: rtl/ioctl_mem_scheduler.sv
// Packs the data_io byte stream into 16-bit memory writes, paces it with clkref_n,
// and arbitrates a single memory port between download writes and CPU accesses.
module ioctl_mem_scheduler #(
  parameter int FIFO_DEPTH = 4,
  parameter int CLKREF_DIV = 4,
  parameter int DL_BURST   = 2
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        clkref_n,
  output logic        dl_busy,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [23:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  input  logic [1:0]  cpu_be,
  output logic        cpu_ack,
  output logic [15:0] cpu_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [23:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic [1:0]  mem_be,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(CLKREF_DIV + 1);
  localparam int BW = $clog2(DL_BURST + 1);
  localparam logic [AW:0]   DEPTH_C = (AW + 1)'(FIFO_DEPTH);
  localparam logic [AW:0]   LIMIT_C = (AW + 1)'(FIFO_DEPTH - 2);
  localparam logic [CW-1:0] DIV_C   = CW'(CLKREF_DIV);
  localparam logic [BW-1:0] BURST_C = BW'(DL_BURST);

  typedef struct packed {
    logic [23:0] addr;
    logic [15:0] data;
    logic [1:0]  be;
  } word_t;

  typedef enum logic [1:0] {S_IDLE, S_DL, S_CPU} state_t;

  // ---------------- byte packing / staging ----------------
  word_t         stg;
  logic          stg_valid;
  logic          dl_prev;
  logic          flush_pend;
  logic          byte_in;
  logic [23:0]   in_addr;
  logic [1:0]    in_be;
  logic [15:0]   in_data;
  logic          flush_req;
  logic          merge;
  logic          push_want;
  logic          fifo_push;
  logic          fifo_pop;

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   fifo_cnt;
  word_t         fifo_mem [FIFO_DEPTH];

  assign byte_in   = ioctl_download & ioctl_wr;
  assign in_addr   = ioctl_addr[24:1];
  assign in_be     = ioctl_addr[0] ? 2'b10 : 2'b01;
  assign in_data   = ioctl_addr[0] ? {ioctl_dout, 8'h00} : {8'h00, ioctl_dout};
  // A flush that could not push (FIFO full) stays pending until it does.
  assign flush_req = (dl_prev & ~ioctl_download) | flush_pend;
  assign merge     = byte_in & stg_valid & ~flush_req & (stg.addr == in_addr) &
                     ((stg.be & in_be) == 2'b00);
  assign push_want = stg_valid & ((stg.be == 2'b11) | flush_req | (byte_in & ~merge));
  assign fifo_push = push_want & ((fifo_cnt != DEPTH_C) | fifo_pop);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    // NOTE: every registered signal uses <= so all flops update from the same pre-edge values.
    if (!reset_n) begin
      stg        <= '0;
      stg_valid  <= 1'b0;
      dl_prev    <= 1'b0;
      flush_pend <= 1'b0;
    end else begin
      dl_prev    <= ioctl_download;
      flush_pend <= flush_req & stg_valid & ~fifo_push;
      if (merge) begin
        stg.be   <= stg.be | in_be;
        stg.data <= stg.data | in_data;
      end else if (byte_in && (!stg_valid || fifo_push)) begin
        stg       <= '{addr: in_addr, data: in_data, be: in_be};
        stg_valid <= 1'b1;
      end else if (fifo_push) begin
        stg_valid <= 1'b0;
      end
    end
  end

  // ---------------- word FIFO ----------------
  // NOTE: the storage array has no reset; pointers and count alone define emptiness.
  always_ff @(posedge clk_sys) begin
    if (fifo_push) fifo_mem[wr_ptr] <= stg;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (fifo_push) wr_ptr <= wr_ptr + 1'b1;
      if (fifo_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({fifo_push, fifo_pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // ---------------- clkref pacing ----------------
  // The staging word is counted as occupied so the byte written after a strobe always fits.
  logic [CW-1:0] since_cnt;
  logic [AW:0]   occupied;
  logic          strobe_ok;

  assign occupied  = fifo_cnt + {{AW{1'b0}}, stg_valid};
  assign strobe_ok = ioctl_download & (occupied <= LIMIT_C) & (since_cnt >= DIV_C);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      clkref_n  <= 1'b1;
      since_cnt <= DIV_C;
    end else begin
      clkref_n <= ~strobe_ok;
      if (strobe_ok)              since_cnt <= CW'(1);
      else if (since_cnt != DIV_C) since_cnt <= since_cnt + 1'b1;
    end
  end

  // ---------------- memory port arbiter ----------------
  state_t        state, state_n;
  logic [BW-1:0] burst_cnt, burst_n;
  logic          mem_req_n, mem_we_n, cpu_ack_n;
  logic [23:0]   mem_addr_n;
  logic [15:0]   mem_wdata_n, cpu_rdata_n;
  logic [1:0]    mem_be_n;
  logic          cpu_req_eff;
  word_t         head;

  // The requester gets the ack cycle to drop cpu_req, so it is not seen then.
  assign cpu_req_eff = cpu_req & ~cpu_ack;
  assign head        = fifo_mem[rd_ptr];

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    state_n     = state;
    burst_n     = burst_cnt;
    fifo_pop    = 1'b0;
    mem_req_n   = mem_req;
    mem_we_n    = mem_we;
    mem_addr_n  = mem_addr;
    mem_wdata_n = mem_wdata;
    mem_be_n    = mem_be;
    cpu_ack_n   = 1'b0;
    cpu_rdata_n = cpu_rdata;
    case (state)
      S_IDLE: begin
        if (!cpu_req_eff) burst_n = '0;
        if ((fifo_cnt != '0) && (!cpu_req_eff || (burst_cnt < BURST_C))) begin
          fifo_pop    = 1'b1;
          mem_req_n   = 1'b1;
          mem_we_n    = 1'b1;
          mem_addr_n  = head.addr;
          mem_wdata_n = head.data;
          mem_be_n    = head.be;
          state_n     = S_DL;
        end else if (cpu_req_eff) begin
          mem_req_n   = 1'b1;
          mem_we_n    = cpu_we;
          mem_addr_n  = cpu_addr;
          mem_wdata_n = cpu_wdata;
          mem_be_n    = cpu_be;
          state_n     = S_CPU;
        end
      end
      S_DL: begin
        if (mem_ack) begin
          mem_req_n = 1'b0;
          if (burst_cnt != BURST_C) burst_n = burst_cnt + 1'b1;
          state_n   = S_IDLE;
        end
      end
      S_CPU: begin
        if (mem_ack) begin
          mem_req_n = 1'b0;
          cpu_ack_n = 1'b1;
          if (!mem_we) cpu_rdata_n = mem_rdata;
          burst_n   = '0;
          state_n   = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      burst_cnt <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      cpu_ack   <= 1'b0;
      cpu_rdata <= '0;
    end else begin
      state     <= state_n;
      burst_cnt <= burst_n;
      mem_req   <= mem_req_n;
      mem_we    <= mem_we_n;
      mem_addr  <= mem_addr_n;
      mem_wdata <= mem_wdata_n;
      mem_be    <= mem_be_n;
      cpu_ack   <= cpu_ack_n;
      cpu_rdata <= cpu_rdata_n;
    end
  end

  assign dl_busy = ioctl_download | stg_valid | (fifo_cnt != '0) | (state == S_DL);

endmodule

// File: tb/tb_ioctl_mem_scheduler.sv
// Directed bench for ioctl_mem_scheduler: a memory responder with programmable ack
// delay, a data_io byte driver that answers clkref_n strobes, and per-scenario checks.
module tb_ioctl_mem_scheduler;
  localparam int FIFO_DEPTH = 4;
  localparam int CLKREF_DIV = 4;
  localparam int DL_BURST   = 2;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        clkref_n;
  logic        dl_busy;
  logic        cpu_req;
  logic        cpu_we;
  logic [23:0] cpu_addr;
  logic [15:0] cpu_wdata;
  logic [1:0]  cpu_be;
  logic        cpu_ack;
  logic [15:0] cpu_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [23:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [1:0]  mem_be;
  logic        mem_ack;
  logic [15:0] mem_rdata;

  ioctl_mem_scheduler #(
    .FIFO_DEPTH(FIFO_DEPTH), .CLKREF_DIV(CLKREF_DIV), .DL_BURST(DL_BURST)
  ) dut (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .clkref_n(clkref_n), .dl_busy(dl_busy),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_be(cpu_be), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk_sys = ~clk_sys;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  // memory responder: acks a request after ack_delay cycles of mem_req, logs on ack
  int          ack_delay = 1;
  bit          ack_hold  = 1'b0;
  int          req_cycles;
  logic [15:0] rdata_val = 16'h0000;
  logic [42:0] mlog[$];

  initial begin
    mem_ack    = 1'b0;
    mem_rdata  = 16'h0000;
    req_cycles = 0;
    forever begin
      @(negedge clk_sys);
      mem_ack   = 1'b0;
      mem_rdata = rdata_val;
      if (!reset_n || !mem_req) begin
        req_cycles = 0;
      end else if (!ack_hold && req_cycles < ack_delay) begin
        req_cycles++;
        if (req_cycles == ack_delay) begin
          mem_ack = 1'b1;
          mlog.push_back({mem_we, mem_addr, mem_wdata, mem_be});
        end
      end
    end
  end

  // data_io model: one byte on the cycle after each observed strobe
  logic [7:0]  drv_data [16];
  logic [24:0] drv_base   = '0;
  int          drv_n      = 0;
  int          drv_idx    = 0;
  bit          drv_active = 1'b0;
  bit          drv_pend   = 1'b0;

  initial begin
    ioctl_wr   = 1'b0;
    ioctl_addr = '0;
    ioctl_dout = '0;
    forever begin
      @(negedge clk_sys);
      ioctl_wr = 1'b0;
      if (drv_pend && drv_active) begin
        ioctl_wr   = 1'b1;
        ioctl_addr = drv_base + 25'(drv_idx);
        ioctl_dout = drv_data[drv_idx];
        drv_idx++;
        drv_pend = 1'b0;
      end else begin
        drv_pend = 1'b0;
        if (drv_active && reset_n && !clkref_n && drv_idx < drv_n) drv_pend = 1'b1;
      end
    end
  end

  // monitors: cpu_ack position, strobe spacing, FIFO overflow
  int cpu_ack_cnt = 0;
  int ack_log_pos = -1;
  int strobe_cnt  = 0;
  int last_strobe = -1000;
  int min_gap     = 1000;
  int ovf_cnt     = 0;

  initial forever begin
    @(negedge clk_sys);
    if (cpu_ack) begin
      cpu_ack_cnt++;
      ack_log_pos = mlog.size();
    end
    if (reset_n && !clkref_n) begin
      if (cyc - last_strobe < min_gap) min_gap = cyc - last_strobe;
      last_strobe = cyc;
      strobe_cnt++;
    end
    if (reset_n && dut.fifo_push && !dut.fifo_pop && int'(dut.fifo_cnt) == FIFO_DEPTH) begin
      $display("FAIL fifo_overflow at cycle %0d: push into %0d-entry FIFO, allowed none", cyc, FIFO_DEPTH);
      ovf_cnt++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic start_dl(input logic [24:0] base, input int n);
    @(negedge clk_sys);
    drv_base = base; drv_n = n; drv_idx = 0; drv_active = 1'b1;
    ioctl_download = 1'b1;
  endtask

  task automatic wait_bytes(input string name, input int n, input int budget);
    int t = 0;
    while (drv_idx < n && t < budget) begin @(negedge clk_sys); t++; end
    n_cmp++;
    if (drv_idx < n) begin
      $display("FAIL %s bytes_sent: got %0d, required %0d", name, drv_idx, n);
      n_bad++;
    end
  endtask

  task automatic end_dl(input string name);
    int t = 0;
    @(negedge clk_sys);
    ioctl_download = 1'b0;
    drv_active     = 1'b0;
    @(negedge clk_sys);
    while ((dl_busy || mem_req) && t < 400) begin @(negedge clk_sys); t++; end
    n_cmp++;
    if (dl_busy || mem_req) begin
      $display("FAIL %s drain: dl_busy=%b mem_req=%b, required both 0", name, dl_busy, mem_req);
      n_bad++;
    end
  endtask

  task automatic wait_cpu_ack(input string name);
    int t = 0;
    while (!cpu_ack && t < 300) begin @(negedge clk_sys); t++; end
    n_cmp++;
    if (!cpu_ack) begin
      $display("FAIL %s cpu_ack: no ack seen, required one", name);
      n_bad++;
    end
    cpu_req = 1'b0;
  endtask

  task automatic check_log(input string name, input int idx, input logic [42:0] exp);
    n_cmp++;
    if (idx >= mlog.size()) begin
      $display("FAIL %s log[%0d]: missing, required %h", name, idx, exp);
      n_bad++;
    end else if (mlog[idx] !== exp) begin
      $display("FAIL %s log[%0d]: got %h, required %h", name, idx, mlog[idx], exp);
      n_bad++;
    end
  endtask

  task automatic check_log_size(input string name, input int exp);
    n_cmp++;
    if (mlog.size() != exp) begin
      $display("FAIL %s log_size: got %0d, required %0d", name, mlog.size(), exp);
      n_bad++;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset_n = 1'b0; ioctl_download = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_be = 2'b00;
    #12;
    n_cmp++;
    if ({clkref_n, dl_busy, cpu_ack, mem_req, mem_we} !== 5'b10000) begin
      $display("FAIL reset ctl: got %b, required 10000", {clkref_n, dl_busy, cpu_ack, mem_req, mem_we});
      n_bad++;
    end
    n_cmp++;
    if ({mem_addr, mem_wdata, mem_be} !== 42'h0) begin
      $display("FAIL reset mem_bus: got %h, required 0", {mem_addr, mem_wdata, mem_be});
      n_bad++;
    end
    n_cmp++;
    if (cpu_rdata !== 16'h0000) begin
      $display("FAIL reset cpu_rdata: got %h, required 0000", cpu_rdata);
      n_bad++;
    end
    repeat (2) @(negedge clk_sys);
    reset_n = 1'b1;
    repeat (2) @(negedge clk_sys);
  endtask

  task automatic test_download_4();
    int acks0 = cpu_ack_cnt;
    mlog.delete();
    drv_data[0] = 8'h11; drv_data[1] = 8'h22; drv_data[2] = 8'h33; drv_data[3] = 8'h44;
    start_dl(25'h0, 4);
    wait_bytes("dl4", 4, 200);
    end_dl("dl4");
    check_log_size("dl4", 2);
    check_log("dl4", 0, {1'b1, 24'h000000, 16'h2211, 2'b11});
    check_log("dl4", 1, {1'b1, 24'h000001, 16'h4433, 2'b11});
    n_cmp++;
    if (cpu_ack_cnt != acks0) begin
      $display("FAIL dl4 cpu_ack_count: got %0d, required %0d", cpu_ack_cnt, acks0);
      n_bad++;
    end
  endtask

  task automatic test_odd_start();
    mlog.delete();
    drv_data[0] = 8'hAB;
    start_dl(25'h5, 1);
    wait_bytes("odd", 1, 100);
    repeat (3) @(negedge clk_sys);
    end_dl("odd");
    check_log_size("odd", 1);
    check_log("odd", 0, {1'b1, 24'h000002, 16'hAB00, 2'b10});
  endtask

  task automatic test_cpu_read();
    int  req_hi = 0;
    int  t = 0;
    bit  addr_bad = 1'b0;
    mlog.delete();
    ack_delay = 7; rdata_val = 16'hBEEF;
    @(negedge clk_sys);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 24'h00ABCD; cpu_wdata = 16'h0000; cpu_be = 2'b11;
    while (!cpu_ack && t < 60) begin
      @(negedge clk_sys); t++;
      if (!cpu_ack && mem_req) begin
        req_hi++;
        if (mem_addr !== 24'h00ABCD) addr_bad = 1'b1;
      end
    end
    n_cmp++;
    if (req_hi != 7) begin
      $display("FAIL cpu_read req_cycles: got %0d, required 7", req_hi);
      n_bad++;
    end
    n_cmp++;
    if (addr_bad) begin
      $display("FAIL cpu_read addr_stable: got unstable, required 00abcd throughout");
      n_bad++;
    end
    wait_cpu_ack("cpu_read");
    n_cmp++;
    if (mem_req !== 1'b0 || cpu_rdata !== 16'hBEEF) begin
      $display("FAIL cpu_read ack_cycle: mem_req=%b rdata=%h, required 0 beef", mem_req, cpu_rdata);
      n_bad++;
    end
    @(negedge clk_sys);
    n_cmp++;
    if (cpu_ack !== 1'b0) begin
      $display("FAIL cpu_read ack_width: got %b one cycle later, required 0", cpu_ack);
      n_bad++;
    end
    check_log("cpu_read", 0, {1'b0, 24'h00ABCD, 16'h0000, 2'b11});
    ack_delay = 1;
  endtask

  task automatic test_contention();
    mlog.delete();
    ack_hold = 1'b1;
    for (int i = 0; i < 8; i++) drv_data[i] = 8'(i + 1);
    start_dl(25'h100, 8);
    repeat (80) @(negedge clk_sys);
    n_cmp++;
    if (drv_idx != 7) begin
      $display("FAIL contention stalled_bytes: got %0d, required 7", drv_idx);
      n_bad++;
    end
    ioctl_download = 1'b0; drv_active = 1'b0;
    rdata_val = 16'h5A5A;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 24'h001234; cpu_wdata = 16'h0000; cpu_be = 2'b11;
    repeat (3) @(negedge clk_sys);
    ack_hold = 1'b0;
    wait_cpu_ack("contention");
    end_dl("contention");
    check_log_size("contention", 5);
    check_log("contention", 0, {1'b1, 24'h000080, 16'h0201, 2'b11});
    check_log("contention", 1, {1'b1, 24'h000081, 16'h0403, 2'b11});
    check_log("contention", 2, {1'b0, 24'h001234, 16'h0000, 2'b11});
    check_log("contention", 3, {1'b1, 24'h000082, 16'h0605, 2'b11});
    check_log("contention", 4, {1'b1, 24'h000083, 16'h0007, 2'b01});
    n_cmp++;
    if (ack_log_pos != 3 || cpu_rdata !== 16'h5A5A) begin
      $display("FAIL contention cpu_ack_pos: pos=%0d rdata=%h, required 3 5a5a", ack_log_pos, cpu_rdata);
      n_bad++;
    end
  endtask

  task automatic test_backpressure();
    int s_mark;
    mlog.delete();
    min_gap = 1000;
    ack_hold = 1'b1;
    for (int i = 0; i < 16; i++) drv_data[i] = 8'(8'hA0 + i);
    start_dl(25'h200, 16);
    repeat (60) @(negedge clk_sys);
    s_mark = strobe_cnt;
    repeat (40) @(negedge clk_sys);
    n_cmp++;
    if (strobe_cnt != s_mark || drv_idx >= 16) begin
      $display("FAIL backpressure stall: strobes %0d->%0d bytes=%0d, required no new strobes",
                s_mark, strobe_cnt, drv_idx);
      n_bad++;
    end
    ack_hold = 1'b0;
    wait_bytes("backpressure", 16, 600);
    end_dl("backpressure");
    check_log_size("backpressure", 8);
    for (int k = 0; k < 8; k++)
      check_log("backpressure", k, {1'b1, 24'h000100 + 24'(k), 8'(8'hA1 + 2 * k), 8'(8'hA0 + 2 * k), 2'b11});
    n_cmp++;
    if (min_gap < CLKREF_DIV) begin
      $display("FAIL backpressure strobe_gap: got %0d, required >= %0d", min_gap, CLKREF_DIV);
      n_bad++;
    end
    n_cmp++;
    if (ovf_cnt != 0) begin
      $display("FAIL backpressure overflow_events: got %0d, required 0", ovf_cnt);
      n_bad++;
    end
  endtask

  task automatic test_reset_mid();
    int t = 0;
    bit noisy = 1'b0;
    mlog.delete();
    ack_hold = 1'b1;
    drv_data[0] = 8'h05; drv_data[1] = 8'h06;
    start_dl(25'h40, 2);
    while (!mem_req && t < 100) begin @(negedge clk_sys); t++; end
    n_cmp++;
    if (!mem_req) begin
      $display("FAIL reset_mid setup: mem_req never rose, required 1");
      n_bad++;
    end
    #2;
    reset_n = 1'b0; ioctl_download = 1'b0; drv_active = 1'b0;
    #1;
    n_cmp++;
    if ({mem_req, clkref_n, dl_busy} !== 3'b010) begin
      $display("FAIL reset_mid async: mem_req/clkref_n/dl_busy=%b, required 010", {mem_req, clkref_n, dl_busy});
      n_bad++;
    end
    repeat (2) @(negedge clk_sys);
    reset_n = 1'b1; ack_hold = 1'b0;
    mlog.delete();
    repeat (10) begin
      @(negedge clk_sys);
      if (mem_req || dl_busy) noisy = 1'b1;
    end
    n_cmp++;
    if (noisy || mlog.size() != 0) begin
      $display("FAIL reset_mid idle_after: activity seen, required FIFO empty and arbiter idle");
      n_bad++;
    end
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 24'h000055; cpu_wdata = 16'hC0DE; cpu_be = 2'b10;
    wait_cpu_ack("reset_mid");
    check_log_size("reset_mid", 1);
    check_log("reset_mid", 0, {1'b1, 24'h000055, 16'hC0DE, 2'b10});
    n_cmp++;
    if (cpu_rdata !== 16'h0000) begin
      $display("FAIL reset_mid write_rdata: got %h, required 0000", cpu_rdata);
      n_bad++;
    end
    @(negedge clk_sys);
  endtask

  initial begin
    test_reset();
    test_download_4();
    test_odd_start();
    test_cpu_read();
    test_contention();
    test_backpressure();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
